// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared types, reset constants and helpers for clk_div_gen.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    // Per-edge channel command; resync outranks enable.
    typedef enum logic [1:0] {
        CMD_HOLD   = 2'd0,
        CMD_RUN    = 2'd1,
        CMD_RESYNC = 2'd2
    } chan_cmd_e;

    localparam logic c_RST_OUT  = 1'b0;
    localparam logic c_RST_TICK = 1'b0;

    function automatic chan_cmd_e decode_cmd(input logic enable, input logic resync);
        chan_cmd_e cmd;
        if (resync) begin
            cmd = CMD_RESYNC;
        end else if (enable) begin
            cmd = CMD_RUN;
        end else begin
            cmd = CMD_HOLD;
        end
        return cmd;
    endfunction

    // Channel i defaults to a half-period of 2^i, saturating at the counter MSB.
    function automatic int unsigned default_half(input int unsigned i, input int unsigned cnt_w);
        int unsigned h;
        if (i < cnt_w) begin
            h = 32'd1 << i;
        end else begin
            h = 32'd1 << (cnt_w - 1);
        end
        return h;
    endfunction

    function automatic int sel_width(input int n);
        int w;
        if (n <= 1) begin
            w = 1;
        end else begin
            w = $clog2(n);
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_if
// Description : Control/config/output bundle of the clock-divider generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_div_if
    import clk_div_pkg::*;
#(
    parameter int NUM_OUT = 3,
    parameter int CNT_W   = 8
);
    localparam int SEL_W = sel_width(NUM_OUT);

    logic               enable;
    logic               resync;
    logic               cfg_we;
    logic [SEL_W-1:0]   cfg_sel;
    logic [CNT_W-1:0]   cfg_div;
    logic [NUM_OUT-1:0] clk_out;
    logic [NUM_OUT-1:0] tick;
    logic [NUM_OUT-1:0] cfg_pend;

    modport master (
        output enable,
        output resync,
        output cfg_we,
        output cfg_sel,
        output cfg_div,
        input  clk_out,
        input  tick,
        input  cfg_pend
    );

    modport slave (
        input  enable,
        input  resync,
        input  cfg_we,
        input  cfg_sel,
        input  cfg_div,
        output clk_out,
        output tick,
        output cfg_pend
    );

endinterface
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_chan
// Description : One 50%-duty divider channel with staged half-period update.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int               CNT_W = 8,
    parameter logic [CNT_W-1:0] RST_H = CNT_W'(1)
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_enable,
    input  wire logic             i_resync,
    input  wire logic             i_wr,
    input  wire logic [CNT_W-1:0] i_wr_div,
    output logic                  o_clk_out,
    output logic                  o_tick,
    output logic                  o_cfg_pend
);

    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_active_h;
    logic [CNT_W-1:0] r_pending_h;
    logic             r_out;
    logic             r_tick;

    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_active_nxt;
    logic [CNT_W-1:0] w_pending_nxt;
    logic             w_out_nxt;
    logic             w_tick_nxt;
    chan_cmd_e        w_cmd;

    always_comb begin
        w_cmd         = decode_cmd(i_enable, i_resync);
        w_cnt_nxt     = r_cnt;
        w_out_nxt     = r_out;
        w_tick_nxt    = 1'b0;
        w_active_nxt  = r_active_h;
        // Writes only touch the staging register; the old value is what loads this edge.
        w_pending_nxt = i_wr ? i_wr_div : r_pending_h;

        case (w_cmd)
            CMD_RESYNC: begin
                w_cnt_nxt    = '0;
                w_out_nxt    = 1'b0;
                w_active_nxt = r_pending_h;
            end
            CMD_RUN: begin
                if (r_cnt == '0) begin
                    w_out_nxt = ~r_out;
                    if (!r_out) begin
                        w_cnt_nxt    = r_pending_h - c_ONE;
                        w_active_nxt = r_pending_h;
                        w_tick_nxt   = 1'b1;
                    end else begin
                        w_cnt_nxt = r_active_h - c_ONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_ONE;
                end
            end
            default: begin
                w_cnt_nxt = r_cnt;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_out       <= c_RST_OUT;
            r_tick      <= c_RST_TICK;
            r_active_h  <= RST_H;
            r_pending_h <= RST_H;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_out       <= w_out_nxt;
            r_tick      <= w_tick_nxt;
            r_active_h  <= w_active_nxt;
            r_pending_h <= w_pending_nxt;
        end
    end

    assign o_clk_out  = r_out;
    assign o_tick     = r_tick;
    assign o_cfg_pend = (r_pending_h != r_active_h);

endmodule
`default_nettype wire

// File: rtl/clk_div_gen.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_gen
// Description : NUM_OUT-channel divided-clock/tick generator with config decode.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int NUM_OUT = 3,
    parameter int CNT_W   = 8
) (
    input  wire logic clk,
    input  wire logic reset,
    clk_div_if.slave  bus
);

    localparam int SEL_W = sel_width(NUM_OUT);

    logic               w_div_ok;
    logic               w_sel_ok;
    logic [NUM_OUT-1:0] w_clk_out;
    logic [NUM_OUT-1:0] w_tick;
    logic [NUM_OUT-1:0] w_cfg_pend;

    // Zero half-periods and out-of-range selects are dropped silently.
    assign w_div_ok = (bus.cfg_div != '0);
    assign w_sel_ok = ({{(32-SEL_W){1'b0}}, bus.cfg_sel} < 32'(NUM_OUT));

    generate
        for (genvar i = 0; i < NUM_OUT; i++) begin : g_chan
            localparam logic [CNT_W-1:0] c_RST_H = CNT_W'(default_half(i, CNT_W));

            logic w_wr;
            assign w_wr = bus.cfg_we & w_sel_ok & w_div_ok & (bus.cfg_sel == SEL_W'(i));

            clk_div_chan #(
                .CNT_W (CNT_W),
                .RST_H (c_RST_H)
            ) u_chan (
                .clk        (clk),
                .reset      (reset),
                .i_enable   (bus.enable),
                .i_resync   (bus.resync),
                .i_wr       (w_wr),
                .i_wr_div   (bus.cfg_div),
                .o_clk_out  (w_clk_out[i]),
                .o_tick     (w_tick[i]),
                .o_cfg_pend (w_cfg_pend[i])
            );
        end
    endgenerate

    assign bus.clk_out  = w_clk_out;
    assign bus.tick     = w_tick;
    assign bus.cfg_pend = w_cfg_pend;

endmodule
`default_nettype wire
